// File: rtl/div8_seq.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake.
// One shift plus one borrow-ripple trial subtract per clock; WIDTH clocks per divide.
module div8_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_dvsr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_dbz;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_sub;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_q_next;

  // Bit-serial borrow ripple over WIDTH+1 bits; returns {borrow_out, diff[WIDTH-1:0]}.
  // The top diff bit is always 0 when no borrow occurs, since the remainder stays below the divisor.
  function automatic logic [WIDTH:0] sub_ripple(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
    logic [WIDTH:0] diff;
    logic           bw;
    bw = 1'b0;
    for (int i = 0; i <= WIDTH; i++) begin
      diff[i] = a[i] ^ b[i] ^ bw;
      bw      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
    end
    return {bw, diff[WIDTH-1:0]};
  endfunction

  // One restoring-division iteration: shift in next dividend bit, trial subtract, keep or restore.
  always_comb begin
    w_trial    = {r_rem, r_q[WIDTH-1]};
    w_sub      = sub_ripple(w_trial, {1'b0, r_dvsr});
    w_borrow   = w_sub[WIDTH];
    w_rem_next = w_borrow ? w_trial[WIDTH-1:0] : w_sub[WIDTH-1:0];
    w_q_next   = {r_q[WIDTH-2:0], ~w_borrow};
  end

  // Next-state logic; DONE accepts a new start exactly like IDLE.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
          w_accept     = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_state_next = S_DONE;
          w_last       = 1'b1;
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_next = S_RUN;
          w_accept     = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; results only change on the final iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rem       <= {WIDTH{1'b0}};
      r_q         <= {WIDTH{1'b0}};
      r_dvsr      <= {WIDTH{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= {WIDTH{1'b0}};
      r_remainder <= {WIDTH{1'b0}};
      r_dbz       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_last;
      if (w_accept) begin
        r_rem  <= {WIDTH{1'b0}};
        r_q    <= dividend;
        r_dvsr <= divisor;
        r_cnt  <= {CNT_W{1'b0}};
        r_busy <= 1'b1;
        r_dbz  <= (divisor == {WIDTH{1'b0}});
      end else if (r_state == S_RUN) begin
        r_rem <= w_rem_next;
        r_q   <= w_q_next;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_busy      <= 1'b0;
          r_quotient  <= w_q_next;
          r_remainder <= w_rem_next;
        end else begin
          r_busy <= 1'b1;
        end
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div8_seq.sv
// Directed self-checking bench for div8_seq (WIDTH=8); inputs driven and outputs sampled on negedge.
module tb_div8_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int total;
  int bad;

  div8_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: pulse start for one edge and measure the outcome (no comparisons here).
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output logic z,
                         output int busy_cyc, output int lat, output logic done_after);
    int k;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    busy_cyc = 0;
    k = 1;
    while (!done && k < 20) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      k++;
    end
    lat = k - 1;
    q = quotient;
    r = remainder;
    z = div_by_zero;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    dividend = 8'd0;
    divisor = 8'd0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      bad++;
      $display("FAIL reset: got busy=%b done=%b q=%0d r=%0d z=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] q, r;
    logic z, da;
    int bc, lat;
    run_div(8'd200, 8'd7, q, r, z, bc, lat, da);
    total++;
    if ({q, r, z} !== {8'd28, 8'd4, 1'b0}) begin
      bad++;
      $display("FAIL basic_200_7: got q=%0d r=%0d z=%b, want q=28 r=4 z=0", q, r, z);
    end
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL basic_latency: got %0d clocks, want 8", lat);
    end
  endtask

  task automatic test_sequence;
    logic [7:0] va [3] = '{8'd255, 8'd5, 8'd0};
    logic [7:0] vb [3] = '{8'd1,   8'd9, 8'd3};
    logic [7:0] eq [3] = '{8'd255, 8'd0, 8'd0};
    logic [7:0] er [3] = '{8'd0,   8'd5, 8'd0};
    logic [7:0] q, r;
    logic z, da;
    int bc, lat;
    for (int i = 0; i < 3; i++) begin
      run_div(va[i], vb[i], q, r, z, bc, lat, da);
      total++;
      if ({q, r, z} !== {eq[i], er[i], 1'b0}) begin
        bad++;
        $display("FAIL seq_%0d: got q=%0d r=%0d z=%b, want q=%0d r=%0d z=0", i, q, r, z, eq[i], er[i]);
      end
      total++;
      if (bc !== 8 || lat !== 8 || da !== 1'b0) begin
        bad++;
        $display("FAIL seq_hs_%0d: got busy=%0d lat=%0d done_next=%b, want 8 8 0", i, bc, lat, da);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [7:0] q, r;
    logic z, da;
    int bc, lat;
    run_div(8'd77, 8'd0, q, r, z, bc, lat, da);
    total++;
    if ({q, r, z} !== {8'd255, 8'd77, 1'b1}) begin
      bad++;
      $display("FAIL div_zero: got q=%0d r=%0d z=%b, want q=255 r=77 z=1", q, r, z);
    end
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL div_zero_latency: got %0d, want 8", lat);
    end
  endtask

  task automatic test_start_while_busy;
    int bc;
    int k;
    dividend = 8'd100;
    divisor  = 8'd10;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    k = 1;
    while (!done && k < 20) begin
      if (busy) bc++;
      if (k == 3) begin
        start = 1'b1;
        dividend = 8'd9;
        divisor = 8'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    total++;
    if ({quotient, remainder} !== {8'd10, 8'd0} || bc !== 8 || k !== 9) begin
      bad++;
      $display("FAIL busy_ignore: got q=%0d r=%0d busy=%0d done_at=%0d, want q=10 r=0 busy=8 done_at=9",
               quotient, remainder, bc, k);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int k;
    dividend = 8'd20;
    divisor  = 8'd6;
    start    = 1'b1;
    @(negedge clk);
    dividend = 8'd45;
    divisor  = 8'd7;
    k = 1;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    total++;
    if ({quotient, remainder} !== {8'd3, 8'd2} || k !== 9) begin
      bad++;
      $display("FAIL b2b_first: got q=%0d r=%0d done_at=%0d, want q=3 r=2 done_at=9", quotient, remainder, k);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept: got busy=%b done=%b after DONE, want busy=1 done=0", busy, done);
    end
    k = 1;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    total++;
    if ({quotient, remainder} !== {8'd6, 8'd3} || k !== 9) begin
      bad++;
      $display("FAIL b2b_second: got q=%0d r=%0d done_at=%0d, want q=6 r=3 done_at=9", quotient, remainder, k);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [7:0] q, r;
    logic z, da;
    int bc, lat;
    dividend = 8'd250;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      bad++;
      $display("FAIL reset_mid: got busy=%b done=%b q=%0d r=%0d z=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    repeat (10) @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
    run_div(8'd250, 8'd3, q, r, z, bc, lat, da);
    total++;
    if ({q, r, z} !== {8'd83, 8'd1, 1'b0}) begin
      bad++;
      $display("FAIL reset_rerun: got q=%0d r=%0d z=%b, want q=83 r=1 z=0", q, r, z);
    end
  endtask

  task automatic test_random;
    logic [7:0] a, b, q, r, eq, er;
    logic z, da;
    int bc, lat;
    for (int i = 0; i < 600; i++) begin
      a = 8'($urandom);
      b = (i % 50 == 0) ? 8'd0 : 8'($urandom);
      run_div(a, b, q, r, z, bc, lat, da);
      eq = (b == 8'd0) ? 8'd255 : a / b;
      er = (b == 8'd0) ? a : a % b;
      total++;
      if ({q, r, z, lat} !== {eq, er, (b == 8'd0), 32'sd8}) begin
        bad++;
        $display("FAIL random %0d/%0d: got q=%0d r=%0d z=%b lat=%0d, want q=%0d r=%0d lat=8",
                 a, b, q, r, z, lat, eq, er);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    dividend = 8'd0;
    divisor = 8'd0;
    test_reset;
    test_basic;
    test_sequence;
    test_div_zero;
    test_start_while_busy;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
